// File: rtl/snake_motion.sv
// snake_motion: move-tick divider, direction latch, head stepping, 20-entry
// head history and apple scoring for the snake game. Motion freezes once the
// downstream collision checker raises game_over; only rst brings it back.
module snake_motion #(
  parameter int STEP      = 10,
  parameter int TICK_DIV  = 2500000,
  parameter int START_X   = 320,
  parameter int START_Y   = 240,
  parameter int MAX_SCORE = 19
) (
  input  logic         vga_clk,
  input  logic         rst,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic [9:0]   apple_x,
  input  logic [9:0]   apple_y,
  input  logic         game_over,
  output logic [9:0]   snakex,
  output logic [9:0]   snakey,
  output logic [199:0] storex,
  output logic [199:0] storey,
  output logic [7:0]   score,
  output logic         ate,
  output logic         move_tick,
  output logic         running
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [9:0]    STEP_V    = 10'(STEP);
  localparam logic [9:0]    START_X_V = 10'(START_X);
  localparam logic [9:0]    START_Y_V = 10'(START_Y);
  localparam logic [7:0]    SCORE_MAX = 8'(MAX_SCORE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // True when b points exactly back along a (a reversal).
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    logic r;
    case (a)
      DIR_UP:    r = (b == DIR_DOWN);
      DIR_DOWN:  r = (b == DIR_UP);
      DIR_LEFT:  r = (b == DIR_RIGHT);
      DIR_RIGHT: r = (b == DIR_LEFT);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  state_t         state_q;
  dir_t           dir_q, pend_q, pend_d, press_dir_s;
  logic [CW-1:0]  cnt_q;
  logic [9:0]     snakex_q, snakey_q, head_x_d, head_y_d;
  logic [199:0]   storex_q, storey_q;
  logic [7:0]     score_q;
  logic           ate_q, move_tick_q, running_q;
  logic           press_any_s, press_ok_s, tick_s, hit_s;

  // Button decode, reversal filter, and the head position a move would produce.
  always_comb begin
    press_any_s = btn_up | btn_down | btn_left | btn_right;
    if (btn_up) begin
      press_dir_s = DIR_UP;
    end else if (btn_down) begin
      press_dir_s = DIR_DOWN;
    end else if (btn_left) begin
      press_dir_s = DIR_LEFT;
    end else begin
      press_dir_s = DIR_RIGHT;
    end
    press_ok_s = press_any_s && !is_opposite(dir_q, press_dir_s);
    if (press_ok_s) begin
      pend_d = press_dir_s;
    end else begin
      pend_d = pend_q;
    end
    tick_s   = (cnt_q == CNT_LAST);
    head_x_d = snakex_q;
    head_y_d = snakey_q;
    case (pend_d)
      DIR_UP:    head_y_d = snakey_q - STEP_V;
      DIR_DOWN:  head_y_d = snakey_q + STEP_V;
      DIR_LEFT:  head_x_d = snakex_q - STEP_V;
      DIR_RIGHT: head_x_d = snakex_q + STEP_V;
      default: begin
        head_x_d = snakex_q;
        head_y_d = snakey_q;
      end
    endcase
    hit_s = (head_x_d == apple_x) && (head_y_d == apple_y);
  end

  // Game FSM with all state, history and registered outputs.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= DIR_RIGHT;
      pend_q      <= DIR_RIGHT;
      cnt_q       <= '0;
      snakex_q    <= START_X_V;
      snakey_q    <= START_Y_V;
      storex_q    <= {20{10'h3FF}};
      storey_q    <= {20{10'h3FF}};
      score_q     <= 8'd0;
      ate_q       <= 1'b0;
      move_tick_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      ate_q       <= 1'b0;
      move_tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (press_any_s) begin
            state_q   <= RUN;
            running_q <= 1'b1;
            dir_q     <= press_dir_s;
            pend_q    <= press_dir_s;
          end
        end
        RUN: begin
          if (game_over) begin
            // Collision wins over any move due this cycle.
            state_q   <= DEAD;
            running_q <= 1'b0;
          end else begin
            pend_q <= pend_d;
            if (tick_s) begin
              cnt_q       <= '0;
              move_tick_q <= 1'b1;
              dir_q       <= pend_d;
              snakex_q    <= head_x_d;
              snakey_q    <= head_y_d;
              storex_q    <= {storex_q[189:0], snakex_q};
              storey_q    <= {storey_q[189:0], snakey_q};
              if (hit_s) begin
                ate_q <= 1'b1;
                if (score_q < SCORE_MAX) begin
                  score_q <= score_q + 8'd1;
                end
              end
            end else begin
              cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end
        DEAD: begin
          running_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign snakex    = snakex_q;
  assign snakey    = snakey_q;
  assign storex    = storex_q;
  assign storey    = storey_q;
  assign score     = score_q;
  assign ate       = ate_q;
  assign move_tick = move_tick_q;
  assign running   = running_q;

endmodule
